// File: rtl/fatpuppy_sweep_pkg.sv
// Shared mode codes, direction codes and FSM state encoding for the VC sweep generator.
package fatpuppy_sweep_pkg;

   localparam logic [1:0] MODE_UP   = 2'd0;
   localparam logic [1:0] MODE_DOWN = 2'd1;
   localparam logic [1:0] MODE_TRI  = 2'd2;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Reserved mode 3 sweeps upward like MODE_UP.
   function automatic logic start_dir(input logic [1:0] mode);
      return (mode == MODE_DOWN) ? DIR_DOWN : DIR_UP;
   endfunction

endpackage

// File: rtl/sweep_step_alu.sv
// Saturating add/subtract of one sweep step; flags when the result is pinned to a rail.
module sweep_step_alu #(
   parameter int WIDTH = 12
) (
   input  logic [WIDTH-1:0] value_i,
   input  logic [WIDTH-1:0] step_i,
   input  logic             dir_i,
   output logic [WIDTH-1:0] next_o,
   output logic             clip_o
);
   import fatpuppy_sweep_pkg::*;

   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] diff_s;

   assign sum_s  = {1'b0, value_i} + {1'b0, step_i};
   assign diff_s = {1'b0, value_i} - {1'b0, step_i};

   // Carry out means overflow past full scale, borrow means below zero.
   always_comb begin
      next_o = value_i;
      clip_o = 1'b0;
      if (dir_i == DIR_DOWN) begin
         if (diff_s[WIDTH]) begin
            next_o = '0;
            clip_o = 1'b1;
         end else begin
            next_o = diff_s[WIDTH-1:0];
            clip_o = 1'b0;
         end
      end else begin
         if (sum_s[WIDTH]) begin
            next_o = '1;
            clip_o = 1'b1;
         end else begin
            next_o = sum_s[WIDTH-1:0];
            clip_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/vc_sweep_gen.sv
// Compensation-voltage DAC code sequencer: one point advance per (repeats+1) enabled ADC ticks,
// with up/down/triangle legs, looping, saturation and abort.
module vc_sweep_gen #(
   parameter int WIDTH = 12,
   parameter int CNTW  = 12
) (
   input  logic             CLK,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic             i_enable,
   input  logic             i_stepTick,
   input  logic [1:0]       i_mode,
   input  logic             i_continuous,
   input  logic [WIDTH-1:0] i_start_val,
   input  logic [WIDTH-1:0] i_step,
   input  logic [CNTW-1:0]  i_steps,
   input  logic [CNTW-1:0]  i_repeats,
   output logic [WIDTH-1:0] o_value,
   output logic             o_stepping,
   output logic [CNTW-1:0]  o_pointIndex,
   output logic             o_busy,
   output logic             o_sweepDone,
   output logic             o_clipped
);
   import fatpuppy_sweep_pkg::*;

   localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [CNTW-1:0]  idx_q, idx_d;
   logic [CNTW-1:0]  rep_q, rep_d;
   logic             dir_q, dir_d;
   logic             clipped_q, clipped_d;
   logic             stepping_q, stepping_d;
   logic             done_q, done_d;
   logic [1:0]       mode_q, mode_d;
   logic             cont_q, cont_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] step_q, step_d;
   logic [CNTW-1:0]  steps_q, steps_d;
   logic [CNTW-1:0]  repeats_q, repeats_d;

   logic             last_s;
   logic             single_s;
   logic             tri_s;
   logic             turn_s;
   logic             alu_dir_s;
   logic [WIDTH-1:0] alu_val_s;
   logic             alu_clip_s;

   // steps_q is stored already normalised, so it is never zero here.
   assign last_s    = (idx_q >= (steps_q - CNT_ONE));
   assign single_s  = (steps_q == CNT_ONE);
   assign tri_s     = (mode_q == MODE_TRI);
   assign turn_s    = last_s & tri_s & ~single_s;
   assign alu_dir_s = turn_s ? ~dir_q : dir_q;

   sweep_step_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .value_i (value_q),
      .step_i  (step_q),
      .dir_i   (alu_dir_s),
      .next_o  (alu_val_s),
      .clip_o  (alu_clip_s)
   );

   // State and datapath registers; reset clears everything including the held value.
   always_ff @(posedge CLK) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         value_q    <= '0;
         idx_q      <= '0;
         rep_q      <= '0;
         dir_q      <= DIR_UP;
         clipped_q  <= 1'b0;
         stepping_q <= 1'b0;
         done_q     <= 1'b0;
         mode_q     <= MODE_UP;
         cont_q     <= 1'b0;
         start_q    <= '0;
         step_q     <= '0;
         steps_q    <= CNT_ONE;
         repeats_q  <= '0;
      end else begin
         state_q    <= state_d;
         value_q    <= value_d;
         idx_q      <= idx_d;
         rep_q      <= rep_d;
         dir_q      <= dir_d;
         clipped_q  <= clipped_d;
         stepping_q <= stepping_d;
         done_q     <= done_d;
         mode_q     <= mode_d;
         cont_q     <= cont_d;
         start_q    <= start_d;
         step_q     <= step_d;
         steps_q    <= steps_d;
         repeats_q  <= repeats_d;
      end
   end

   // Next-state logic: abort beats start, and both swallow a coincident tick.
   always_comb begin
      state_d    = state_q;
      value_d    = value_q;
      idx_d      = idx_q;
      rep_d      = rep_q;
      dir_d      = dir_q;
      clipped_d  = clipped_q;
      stepping_d = 1'b0;
      done_d     = 1'b0;
      mode_d     = mode_q;
      cont_d     = cont_q;
      start_d    = start_q;
      step_d     = step_q;
      steps_d    = steps_q;
      repeats_d  = repeats_q;

      if (i_abort) begin
         state_d = ST_IDLE;
      end else if (i_start) begin
         mode_d     = i_mode;
         cont_d     = i_continuous;
         start_d    = i_start_val;
         step_d     = i_step;
         steps_d    = (i_steps == '0) ? CNT_ONE : i_steps;
         repeats_d  = i_repeats;
         value_d    = i_start_val;
         idx_d      = '0;
         rep_d      = '0;
         clipped_d  = 1'b0;
         dir_d      = start_dir(i_mode);
         stepping_d = 1'b1;
         state_d    = ST_RUN;
      end else if ((state_q == ST_RUN) && i_stepTick && i_enable) begin
         if (rep_q < repeats_q) begin
            rep_d = rep_q + CNT_ONE;
         end else begin
            rep_d = '0;
            if (!last_s) begin
               idx_d      = idx_q + CNT_ONE;
               value_d    = alu_val_s;
               clipped_d  = clipped_q | alu_clip_s;
               stepping_d = 1'b1;
            end else if (!tri_s || single_s) begin
               // End of a straight sweep (or a one-point triangle): loop back or stop.
               done_d = 1'b1;
               if (cont_q) begin
                  value_d    = start_q;
                  idx_d      = '0;
                  stepping_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (dir_q == DIR_UP) begin
               dir_d      = DIR_DOWN;
               idx_d      = CNT_ONE;
               value_d    = alu_val_s;
               clipped_d  = clipped_q | alu_clip_s;
               stepping_d = 1'b1;
            end else begin
               done_d = 1'b1;
               if (cont_q) begin
                  dir_d      = DIR_UP;
                  idx_d      = CNT_ONE;
                  value_d    = alu_val_s;
                  clipped_d  = clipped_q | alu_clip_s;
                  stepping_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
      end else begin
         state_d = state_q;
      end
   end

   assign o_value      = value_q;
   assign o_stepping   = stepping_q;
   assign o_pointIndex = idx_q;
   assign o_busy       = (state_q == ST_RUN);
   assign o_sweepDone  = done_q;
   assign o_clipped    = clipped_q;

endmodule

// File: doc/vc_sweep_gen.md
Name: vc_sweep_gen

Overview:
Parametrised successor to the VC sweep generator. Produces the compensation-voltage DAC code sequence, advancing once per ADC word strobe. Adds selectable width, up/down/triangle modes, continuous looping, saturation with a sticky clip flag, abort, and a point index for tagging readout frames. Sits between cmdParser outputs and the mcp4921 DAC driver; o_stepping drives the DAC trigger.

Parameters:
WIDTH, 12, DAC code width (value, start, step)
CNTW, 12, width of the steps, repeats and point-index counters

Ports:
CLK  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  one-cycle pulse: latch parameters and begin a sweep
i_abort  in  1  one-cycle pulse: stop the sweep and hold the current value
i_enable  in  1  pause gate; ticks are ignored while low
i_stepTick  in  1  one-cycle pulse per ADC word (already synchronised to CLK)
i_mode  in  2  0=UP, 1=DOWN, 2=TRIANGLE, 3=reserved (treated as UP)
i_continuous  in  1  1 = loop forever, 0 = one-shot
i_start_val  in  WIDTH  first code
i_step  in  WIDTH  code increment per point
i_steps  in  CNTW  points per leg; 0 is treated as 1
i_repeats  in  CNTW  extra ticks per point; dwell is repeats+1 ticks
o_value  out  WIDTH  current DAC code
o_stepping  out  1  one-cycle pulse when o_value is loaded or changed
o_pointIndex  out  CNTW  index of the current point within the leg
o_busy  out  1  high while in RUN
o_sweepDone  out  1  one-cycle pulse at the end of each sweep or loop
o_clipped  out  1  sticky: saturation occurred since the last i_start

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-sweep returns to IDLE immediately; the value is not held.
- States:
  - IDLE: waits for i_start.
  - RUN: dwell and advance.
- No separate DONE state; the transition RUN->IDLE pulses o_sweepDone.
- i_start, in any state:
  - Latch all i_* parameters.
  - o_value<=i_start_val, idx<=0, repeat counter<=0, o_clipped<=0, direction<=(mode==DOWN ? down : up).
  - o_stepping pulses in the next cycle.
  - Next state RUN.
- i_abort: next state IDLE; o_value and o_pointIndex hold. No o_sweepDone.
- Same-cycle priority: reset > abort > start > tick. A tick coincident with start or abort is dropped.
- Counting in RUN: counts only when i_stepTick & i_enable.
  - If rep < repeats: rep++.
  - Otherwise rep<=0 and the point advances.
- Advance, not at the last point of the leg (idx < steps-1):
  - idx++.
  - o_value <= value ± step. Add on up, subtract on down.
  - o_stepping pulses one cycle later; latency from tick to new value is 1 cycle.
- Advance at the last point of the leg:
  - UP or DOWN, one-shot: pulse o_sweepDone, go to IDLE, o_value holds.
  - UP or DOWN, continuous: reload start_val, idx<=0, pulse o_sweepDone and o_stepping.
  - TRIANGLE, up leg: flip direction, idx<=1, o_value<=value-step. The turn point is not repeated.
  - TRIANGLE, down leg: this means the value is back at start. One-shot: o_sweepDone and IDLE. Continuous: o_sweepDone, flip up, idx<=1, value+step.
- steps==1: every advance is the last point; the value stays at start and the done/loop logic still runs.
- Arithmetic: computed at WIDTH+1 bits and saturated to [0, 2^WIDTH-1]. On saturation, o_clipped<=1. The sweep continues at the rail, and o_stepping still pulses.
- i_enable low: state and counters freeze; the first enabled tick resumes the count.

Decomposition:
- Package fatpuppy_sweep_pkg:
  - Mode constants MODE_UP, MODE_DOWN, MODE_TRI.
  - State encoding ST_IDLE, ST_RUN.
- Sub-module sweep_step_alu (combinational):
  - Inputs: value, step, direction.
  - Outputs: next value (saturated), clip.
  - Parametrised by WIDTH.

Test Plan:
- UP one-shot, start=100, step=10, steps=4, repeats=1, 8 ticks: o_value 100,100,110,110,120,120,130,130, then o_sweepDone on the 8th tick and o_busy=0, o_value holds 130. o_stepping pulses 4 times.
- TRIANGLE continuous, start=10, step=5, steps=3, repeats=0: values 10,15,20,15,10,15,20; o_sweepDone on each return to 10; o_pointIndex 0,1,2,1,2,1,2.
- DOWN, start=15, step=10, steps=3, WIDTH=12: values 15, 5, then 0 with o_clipped=1 and o_stepping pulsed. A new i_start clears o_clipped.
- Abort on the same cycle as i_stepTick mid-dwell: no advance, IDLE, value held, no o_sweepDone. i_start coincident with a tick: start value is loaded and the tick is dropped.
- i_enable=0 for 5 ticks mid-dwell: no change. On re-enable the dwell resumes at the saved repeat count; the point changes after the remaining ticks.
- i_reset asserted mid-sweep: the next cycle shows all outputs 0 and IDLE. steps=0 behaves as steps=1 (single point, done after repeats+1 ticks).
